// File: rtl/r_cpu_ctrl.sv
// Multi-cycle Moore control unit for the R-type datapath: sequences IF/ID/EX/WB,
// issues one-cycle write strobes, traps illegal instructions and counts retired ones.
module r_cpu_ctrl #(
   parameter int ICNT_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              step,
   input  logic [5:0]        OP,
   input  logic [5:0]        func,
   input  logic [4:0]        rd,
   output logic              PC_Write,
   output logic              IR_Write,
   output logic              AB_Write,
   output logic              F_Write,
   output logic              Flag_Write,
   output logic              OF_En,
   output logic              Reg_Write,
   output logic [3:0]        ALU_OP,
   output logic [2:0]        state,
   output logic              illegal,
   output logic [ICNT_W-1:0] icount
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_IF   = 3'd1;
   localparam logic [2:0] S_ID   = 3'd2;
   localparam logic [2:0] S_EX   = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;

   logic       dec_legal;
   logic [3:0] dec_op;
   logic [2:0] state_nx;

   always_comb begin
      dec_legal = (OP == 6'b000000);
      dec_op    = 4'b0000;
      case (func)
         6'b100100: dec_op = 4'b0000;
         6'b100101: dec_op = 4'b0001;
         6'b100110: dec_op = 4'b0010;
         6'b100111: dec_op = 4'b0011;
         6'b100000: dec_op = 4'b0100;
         6'b100010: dec_op = 4'b0101;
         6'b101011: dec_op = 4'b0110;
         6'b000100: dec_op = 4'b0111;
         default:   dec_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_nx = S_IDLE;
      case (state)
         S_IDLE:  state_nx = (run | step) ? S_IF : S_IDLE;
         S_IF:    state_nx = S_ID;
         S_ID:    state_nx = dec_legal ? S_EX : S_ERR;
         S_EX:    state_nx = S_WB;
         S_WB:    state_nx = run ? S_IF : S_IDLE;
         S_ERR:   state_nx = S_ERR;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= S_IDLE;
         ALU_OP <= 4'b0000;
         icount <= '0;
      end else begin
         state <= state_nx;
         // ALU_OP is captured only on a legal decode, so it holds through EX/WB/IDLE
         if (state == S_ID && dec_legal) ALU_OP <= dec_op;
         if (state == S_WB) icount <= icount + ICNT_W'(1);
      end
   end

   // Strobes decode purely from registered state, so reset kills them at once
   always_comb begin
      PC_Write   = 1'b0;
      IR_Write   = 1'b0;
      AB_Write   = 1'b0;
      F_Write    = 1'b0;
      Flag_Write = 1'b0;
      OF_En      = 1'b0;
      Reg_Write  = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_IF: begin
            PC_Write = 1'b1;
            IR_Write = 1'b1;
         end
         S_ID: AB_Write = 1'b1;
         S_EX: begin
            F_Write    = 1'b1;
            Flag_Write = 1'b1;
            OF_En      = (ALU_OP == 4'b0100) || (ALU_OP == 4'b0101);
         end
         S_WB:  Reg_Write = (rd != 5'd0);
         S_ERR: illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_r_cpu_ctrl.sv
// Directed bench for r_cpu_ctrl: per-cycle expectations are queued as stimulus is
// driven and popped/compared against the DUT one time unit after each rising edge.
module tb_r_cpu_ctrl;

   localparam int ICNT_W = 4;

   localparam logic [2:0] IDLE = 3'd0, IF = 3'd1, ID = 3'd2, EX = 3'd3, WB = 3'd4, ERR = 3'd5;
   // {PC_Write, IR_Write, AB_Write, F_Write, Flag_Write, OF_En, Reg_Write}
   localparam logic [6:0] B_NONE = 7'b0000000;
   localparam logic [6:0] B_IF   = 7'b1100000;
   localparam logic [6:0] B_ID   = 7'b0010000;
   localparam logic [6:0] B_EXO  = 7'b0001110;
   localparam logic [6:0] B_EXN  = 7'b0001100;
   localparam logic [6:0] B_WB   = 7'b0000001;

   typedef struct {
      logic [2:0]        st;
      logic [6:0]        stb;
      logic [3:0]        aop;
      logic [ICNT_W-1:0] ic;
      logic              ill;
   } exp_t;

   logic clk, reset, run, step;
   logic [5:0] OP, func;
   logic [4:0] rd;
   logic PC_Write, IR_Write, AB_Write, F_Write, Flag_Write, OF_En, Reg_Write;
   logic [3:0] ALU_OP;
   logic [2:0] state;
   logic illegal;
   logic [ICNT_W-1:0] icount;

   exp_t  q[$];
   int    errors = 0;
   int    checks = 0;
   string phase  = "init";

   r_cpu_ctrl #(.ICNT_W(ICNT_W)) dut (
      .clk(clk), .reset(reset), .run(run), .step(step),
      .OP(OP), .func(func), .rd(rd),
      .PC_Write(PC_Write), .IR_Write(IR_Write), .AB_Write(AB_Write),
      .F_Write(F_Write), .Flag_Write(Flag_Write), .OF_En(OF_En),
      .Reg_Write(Reg_Write), .ALU_OP(ALU_OP), .state(state),
      .illegal(illegal), .icount(icount)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not complete");
      $fatal(1, "timeout");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] st, input logic [6:0] stb, input logic [3:0] aop,
                       input int ic, input logic ill);
      exp_t e;
      e.st = st; e.stb = stb; e.aop = aop; e.ic = ic[ICNT_W-1:0]; e.ill = ill;
      q.push_back(e);
   endtask

   task automatic check_top();
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s/queue: observed empty expected entry", phase);
      end else begin
         e = q.pop_front();
         chk("state",   32'(state), 32'(e.st));
         chk("strobes", 32'({PC_Write, IR_Write, AB_Write, F_Write, Flag_Write, OF_En, Reg_Write}),
             32'(e.stb));
         chk("alu_op",  32'(ALU_OP), 32'(e.aop));
         chk("icount",  32'(icount), 32'(e.ic));
         chk("illegal", 32'(illegal), 32'(e.ill));
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
      check_top();
   endtask

   initial begin
      reset = 1'b1; run = 1'b0; step = 1'b0;
      OP = 6'b0; func = 6'b100000; rd = 5'd3;
      repeat (2) @(posedge clk);
      #1;
      phase = "reset";
      push(IDLE, B_NONE, 4'h0, 0, 1'b0); check_top();
      reset = 1'b0;
      push(IDLE, B_NONE, 4'h0, 0, 1'b0); cyc();

      // add under run: two full passes then an async reset in EX of the third
      phase = "run_add";
      run = 1'b1; OP = 6'b000000; func = 6'b100000; rd = 5'd3;
      push(IF, B_IF,  4'h0, 0, 1'b0); cyc();
      push(ID, B_ID,  4'h0, 0, 1'b0); cyc();
      push(EX, B_EXO, 4'h4, 0, 1'b0); cyc();
      push(WB, B_WB,  4'h4, 0, 1'b0); cyc();
      push(IF, B_IF,  4'h4, 1, 1'b0); cyc();
      push(ID, B_ID,  4'h4, 1, 1'b0); cyc();
      push(EX, B_EXO, 4'h4, 1, 1'b0); cyc();
      push(WB, B_WB,  4'h4, 1, 1'b0); cyc();
      push(IF, B_IF,  4'h4, 2, 1'b0); cyc();
      push(ID, B_ID,  4'h4, 2, 1'b0); cyc();
      push(EX, B_EXO, 4'h4, 2, 1'b0); cyc();
      phase = "async_reset";
      #2 reset = 1'b1; run = 1'b0;
      #1;
      push(IDLE, B_NONE, 4'h0, 0, 1'b0); check_top();
      push(IDLE, B_NONE, 4'h0, 0, 1'b0); cyc();
      reset = 1'b0;
      push(IDLE, B_NONE, 4'h0, 0, 1'b0); cyc();

      // single step xor; a second step pulse during EX must be ignored
      phase = "step_xor";
      step = 1'b1; func = 6'b100110; rd = 5'd5;
      push(IF, B_IF, 4'h0, 0, 1'b0); cyc();
      step = 1'b0;
      push(ID, B_ID, 4'h0, 0, 1'b0); cyc();
      push(EX, B_EXN, 4'h2, 0, 1'b0); cyc();
      step = 1'b1;
      push(WB, B_WB, 4'h2, 0, 1'b0); cyc();
      step = 1'b0;
      push(IDLE, B_NONE, 4'h2, 1, 1'b0); cyc();
      push(IDLE, B_NONE, 4'h2, 1, 1'b0); cyc();

      // and with rd=0: no Reg_Write, icount still counts; run dropped in WB
      phase = "rd0_and";
      run = 1'b1; func = 6'b100100; rd = 5'd0;
      push(IF, B_IF, 4'h2, 1, 1'b0); cyc();
      push(ID, B_ID, 4'h2, 1, 1'b0); cyc();
      push(EX, B_EXN, 4'h0, 1, 1'b0); cyc();
      push(WB, B_NONE, 4'h0, 1, 1'b0); cyc();
      run = 1'b0;
      push(IDLE, B_NONE, 4'h0, 2, 1'b0); cyc();

      // illegal opcode traps to ERR and sticks there until reset
      phase = "illegal";
      run = 1'b1; OP = 6'b001000; func = 6'b100000; rd = 5'd3;
      push(IF, B_IF, 4'h0, 2, 1'b0); cyc();
      push(ID, B_ID, 4'h0, 2, 1'b0); cyc();
      for (int i = 0; i < 5; i++) begin
         push(ERR, B_NONE, 4'h0, 2, 1'b1); cyc();
      end
      reset = 1'b1;
      push(IDLE, B_NONE, 4'h0, 0, 1'b0); cyc();
      run = 1'b0; OP = 6'b000000;
      reset = 1'b0;
      push(IDLE, B_NONE, 4'h0, 0, 1'b0); cyc();

      // 16 adds wrap a 4-bit icount to 0; run drops during ID of the 17th
      phase = "wrap";
      run = 1'b1; func = 6'b100000; rd = 5'd7;
      for (int i = 0; i < 16; i++) begin
         push(IF, B_IF,  (i == 0) ? 4'h0 : 4'h4, i, 1'b0); cyc();
         push(ID, B_ID,  (i == 0) ? 4'h0 : 4'h4, i, 1'b0); cyc();
         push(EX, B_EXO, 4'h4, i, 1'b0); cyc();
         push(WB, B_WB,  4'h4, i, 1'b0); cyc();
      end
      phase = "run_drop";
      push(IF, B_IF, 4'h4, 0, 1'b0); cyc();
      push(ID, B_ID, 4'h4, 0, 1'b0); cyc();
      run = 1'b0;
      push(EX, B_EXO, 4'h4, 0, 1'b0); cyc();
      push(WB, B_WB,  4'h4, 0, 1'b0); cyc();
      push(IDLE, B_NONE, 4'h4, 1, 1'b0); cyc();
      push(IDLE, B_NONE, 4'h4, 1, 1'b0); cyc();

      if (q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL leftover: observed %0d queued expected 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/r_cpu_ctrl.md
# r_cpu_ctrl

Multi-cycle control unit that sequences the R-type datapath (fetch, decode, register file, ALU) through explicit fetch/decode/execute/writeback phases. It replaces the single-cycle combinational decode with a Moore FSM that issues one-cycle write strobes to the PC, instruction register, operand latches, result/flag latches and register file. It adds run/single-step control, illegal-instruction trapping and a retired-instruction counter. It sits between the instruction register and the datapath enables inside the CPU top level.

## Interface
- ICNT_W, 16, width of retired-instruction counter
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces all state and outputs to reset values
- run  in  1  level; continuous execution while high
- step  in  1  single-cycle pulse; executes exactly one instruction when sampled in IDLE
- OP  in  6  instruction register bits [31:26]
- func  in  6  instruction register bits [5:0]
- rd  in  5  instruction register bits [15:11]
- PC_Write  out  1  PC <= PC+4 strobe
- IR_Write  out  1  instruction register load strobe
- AB_Write  out  1  operand latch (R_Data_A/B) load strobe
- F_Write  out  1  ALU result latch load strobe
- Flag_Write  out  1  ZF/OF latch load strobe
- OF_En  out  1  1: latch ALU OF; 0: latch OF as 0
- Reg_Write  out  1  register file write strobe
- ALU_OP  out  4  registered ALU operation
- state  out  3  current FSM state (debug)
- illegal  out  1  sticky illegal-instruction flag
- icount  out  ICNT_W  retired-instruction count

## Operation
- States (encoding): IDLE 0, IF 1, ID 2, EX 3, WB 4, ERR 5; codes 6–7 go to IDLE next cycle.
- IDLE: all strobes 0. run|step -> IF; else stay.
- IF: IR_Write=1, PC_Write=1. -> ID.
- ID: AB_Write=1. Decode OP/func; legal -> EX with ALU_OP registered on this edge; illegal -> ERR.
- EX: F_Write=1, Flag_Write=1, OF_En=1 only when ALU_OP is 0100 or 0101. -> WB.
- WB: Reg_Write=1 unless rd==0; icount+1. run -> IF; else -> IDLE.
- ERR: all strobes 0, illegal=1; stays until reset.
- Legal only when OP==000000. func -> ALU_OP: 100100 and 0000; 100101 or 0001; 100110 xor 0010; 100111 nor 0011; 100000 add 0100; 100010 sub 0101; 101011 sltu 0110; 000100 sllv 0111. Any other func or nonzero OP is illegal.
- Strobes are Moore outputs decoded from registered state; exactly one state active per cycle; no strobe asserted in two consecutive states.
- icount wraps modulo 2^ICNT_W; increments only in WB.
- ALU_OP holds its value from ID through WB and in IDLE until the next ID.

## Timing
- Reset values: state IDLE, every strobe 0, ALU_OP 0000, illegal 0, icount 0, OF_En 0.
- Reset is asynchronous; asserting it mid-instruction aborts immediately with no partial write. First IF occurs on the first edge after release with run|step high.
- CPI = 4 under run; WB->IF back-to-back, no bubble.
- Startup: run high in IDLE at edge n -> IF in cycle n+1, Reg_Write in cycle n+4.
- step is sampled only in IDLE; pulses in other states are ignored. step and run both high: behaves as run.
- run dropped mid-instruction: the instruction completes through WB, then IDLE.
- Illegal: ERR is entered the cycle after ID. No F_Write, Flag_Write, Reg_Write or icount change for that instruction. The PC has already advanced.

## Test plan
- Reset: assert reset asynchronously mid-EX -> state 0, all strobes 0 in the same cycle, icount 0, ALU_OP 0000.
- run=1, add (OP 0, func 100000, rd 3) -> state sequence 1,2,3,4 repeating; ALU_OP 0100; OF_En=1 in EX; Reg_Write in WB; icount 1 after the first WB.
- Single-step: one step pulse with xor (func 100110) -> one pass IF..WB, then IDLE; ALU_OP 0010; OF_En=0; icount +1. A second step pulse during EX is ignored.
- rd=0 and (func 100100) under run -> all strobes present except Reg_Write; icount still increments.
- Illegal: OP=001000 -> IF, ID, then ERR; illegal=1 held indefinitely, no Reg_Write, icount unchanged. Reset clears illegal to 0.
- Wrap and run drop: ICNT_W=4, run 16 instructions -> icount 0; drop run during ID of the 17th -> that instruction completes, then IDLE with icount 1.
